alu_op_sequencer: RTL and testbench

//  Issue stage in front of ArithmeticLogicUnit. Accepts one ALU operation per request over a

---
 rtl/alu_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Issue stage in front of an ArithmeticLogicUnit. Takes one ALU operation per
// valid/ready handshake, reads its operands from a small local register file,
// presents them to the ALU for exactly one ISSUE cycle and writes the ALU
// result back to the destination register at the end of that cycle. An op can
// be made conditional on one of the ALU's registered flags.
//
// Ports
//   Clock, Reset               clock, asynchronous active-low reset
//   ReqValid/ReqReady          request handshake
//   ReqFunSel, ReqSrcA/B,      op fields: function, operand registers,
//   ReqImmEn, ReqImm, ReqDst,  immediate select/value, writeback register,
//   ReqWF, ReqCondEn, ReqCond  flag-write request, conditional execution
//   AluA, AluB, AluFunSel,     operands/function/flag-write to the ALU
//   AluWF
//   AluOut, AluFlags           ALU result (combinational), flags {Z,C,N,O}
//   Done, Skipped              retire pulse; Skipped=1 when condition failed
//   RdSel, RdData              combinational debug read port
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int NREG   = 8,
  parameter int RSEL_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [4:0]        ReqFunSel,
  input  logic [RSEL_W-1:0] ReqSrcA,
  input  logic [RSEL_W-1:0] ReqSrcB,
  input  logic              ReqImmEn,
  input  logic [31:0]       ReqImm,
  input  logic [RSEL_W-1:0] ReqDst,
  input  logic              ReqWF,
  input  logic              ReqCondEn,
  input  logic [1:0]        ReqCond,
  output logic [31:0]       AluA,
  output logic [31:0]       AluB,
  output logic [4:0]        AluFunSel,
  output logic              AluWF,
  input  logic [31:0]       AluOut,
  input  logic [3:0]        AluFlags,
  output logic              Done,
  output logic              Skipped,
  input  logic [RSEL_W-1:0] RdSel,
  output logic [31:0]       RdData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RETIRE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         regs_q [NREG];
  logic [31:0]         alu_a_q, alu_b_q;
  logic [4:0]          funsel_q;
  logic [RSEL_W-1:0]   dst_q;
  logic                wf_q, cond_en_q;
  logic [1:0]          cond_q;
  logic                done_q, skipped_q;
  logic                accept_s, issue_s, ok_s;
  logic [31:0]         wb_data_s;

  // Next-state logic and ready generation.
  always_comb begin
    state_d  = state_q;
    ReqReady = 1'b0;
    case (state_q)
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_RETIRE;
      end
      S_RETIRE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    accept_s = ReqValid & ReqReady;
  end

  // Condition evaluation, flag-write gating and writeback width merge.
  // AluWF is qualified by the live state so an async reset removes it at once.
  always_comb begin
    issue_s = (state_q == S_ISSUE);
    ok_s    = ~cond_en_q | AluFlags[cond_q];
    if (issue_s) begin
      AluWF = wf_q & ok_s;
    end else begin
      AluWF = 1'b0;
    end
    if (funsel_q[4]) begin
      wb_data_s = AluOut;
    end else begin
      // 16-bit ops only replace the low half of the destination.
      wb_data_s = {regs_q[dst_q][31:16], AluOut[15:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch. Operands are captured at the accept edge; no register can
  // change between that edge and the end of ISSUE, so this equals reading the
  // file during ISSUE and keeps the ALU inputs glitch-free registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      funsel_q  <= 5'd0;
      dst_q     <= '0;
      wf_q      <= 1'b0;
      cond_en_q <= 1'b0;
      cond_q    <= 2'd0;
    end else if (accept_s) begin
      alu_a_q   <= regs_q[ReqSrcA];
      alu_b_q   <= ReqImmEn ? ReqImm : regs_q[ReqSrcB];
      funsel_q  <= ReqFunSel;
      dst_q     <= ReqDst;
      wf_q      <= ReqWF;
      cond_en_q <= ReqCondEn;
      cond_q    <= ReqCond;
    end
  end

  // Retire pulse, raised for the cycle following ISSUE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      done_q    <= issue_s;
      skipped_q <= issue_s & ~ok_s;
    end
  end

  // Register file with writeback at the closing edge of ISSUE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (issue_s && ok_s) begin
      regs_q[dst_q] <= wb_data_s;
    end
  end

  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign AluFunSel = funsel_q;
  assign Done      = done_q;
  assign Skipped   = skipped_q;
  assign RdData    = regs_q[RdSel];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached.
module tb_alu_op_sequencer;

  logic        Clock, Reset;
  logic        ReqValid, ReqReady;
  logic [4:0]  ReqFunSel;
  logic [2:0]  ReqSrcA, ReqSrcB, ReqDst, RdSel;
  logic        ReqImmEn, ReqWF, ReqCondEn;
  logic [31:0] ReqImm;
  logic [1:0]  ReqCond;
  logic [31:0] AluA, AluB, AluOut, RdData;
  logic [4:0]  AluFunSel;
  logic        AluWF, Done, Skipped;
  logic [3:0]  AluFlags;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.NREG(8), .RSEL_W(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqFunSel(ReqFunSel), .ReqSrcA(ReqSrcA), .ReqSrcB(ReqSrcB),
    .ReqImmEn(ReqImmEn), .ReqImm(ReqImm), .ReqDst(ReqDst),
    .ReqWF(ReqWF), .ReqCondEn(ReqCondEn), .ReqCond(ReqCond),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags),
    .Done(Done), .Skipped(Skipped),
    .RdSel(RdSel), .RdData(RdData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural ALU (subset of FunSel codes) ----------------
  logic [3:0]  flags_q;
  logic [3:0]  nflags;
  logic [31:0] aa, bb, res;
  logic [32:0] sum;
  logic        cin, arith, z, c, n, o;

  always_comb begin
    aa    = AluFunSel[4] ? AluA : {16'h0000, AluA[15:0]};
    bb    = AluFunSel[4] ? AluB : {16'h0000, AluB[15:0]};
    cin   = (AluFunSel[3:0] == 4'h5) ? flags_q[2] : 1'b0;
    sum   = {1'b0, aa} + {1'b0, bb} + {32'd0, cin};
    arith = (AluFunSel[3:0] == 4'h4) || (AluFunSel[3:0] == 4'h5);
    case (AluFunSel[3:0])
      4'h0:    res = aa;
      4'h1:    res = bb;
      4'h2:    res = ~aa;
      4'h3:    res = ~bb;
      4'h4:    res = sum[31:0];
      4'h5:    res = sum[31:0];
      default: res = aa;
    endcase
    if (!AluFunSel[4]) res = {16'h0000, res[15:0]};
    if (AluFunSel[4]) begin
      z = (res == 32'd0); c = sum[32]; n = res[31];
      o = (aa[31] == bb[31]) && (res[31] != aa[31]);
    end else begin
      z = (res[15:0] == 16'd0); c = sum[16]; n = res[15];
      o = (aa[15] == bb[15]) && (res[15] != aa[15]);
    end
    nflags = {z, arith ? c : flags_q[2], n, arith ? o : flags_q[0]};
  end

  assign AluOut   = res;
  assign AluFlags = flags_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) flags_q <= 4'd0;
    else if (AluWF) flags_q <= nflags;
  end

  // ---------------- op driver (no checking here) ----------------
  // Returns the number of negedges from the accept edge until Done (99 = timeout).
  task automatic do_op(input logic [4:0] fs, input logic [2:0] sa, input logic [2:0] sb,
                       input logic ie, input logic [31:0] imm, input logic [2:0] dst,
                       input logic wf, input logic ce, input logic [1:0] cd,
                       output int lat, output logic skp, output logic wf_seen);
    int n_wait;
    @(negedge Clock);
    ReqFunSel = fs; ReqSrcA = sa; ReqSrcB = sb; ReqImmEn = ie; ReqImm = imm;
    ReqDst = dst; ReqWF = wf; ReqCondEn = ce; ReqCond = cd; ReqValid = 1'b1;
    lat = 99; skp = 1'b0; wf_seen = 1'b0;
    n_wait = 0;
    while (!ReqReady && n_wait < 10) begin
      @(negedge Clock);
      n_wait++;
    end
    if (n_wait < 10) begin
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge Clock);
        if (AluWF) wf_seen = 1'b1;
        if (Done) begin
          lat = k;
          skp = Skipped;
          break;
        end
      end
    end else begin
      ReqValid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0; ReqValid = 1'b0; ReqFunSel = 5'd0; ReqSrcA = 3'd0; ReqSrcB = 3'd0;
    ReqImmEn = 1'b0; ReqImm = 32'd0; ReqDst = 3'd0; ReqWF = 1'b0; ReqCondEn = 1'b0;
    ReqCond = 2'd0; RdSel = 3'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      RdSel = 3'(i);
      #1;
      checks++; if (RdData !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00000000", i, RdData); end
    end
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ReqReady); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (AluWF !== 1'b0) begin errors++; $display("FAIL reset_wf: got %b expected 0", AluWF); end
    checks++; if ({AluA, AluB, AluFunSel} !== 69'd0) begin errors++; $display("FAIL reset_alu_ins: got %h %h %h expected 0", AluA, AluB, AluFunSel); end
  endtask

  task automatic test_load_add();
    int lat; logic skp, wfs;
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'h0000FFFF, 3'd1, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", lat); end
    RdSel = 3'd1; #1;
    checks++; if (RdData !== 32'h0000FFFF) begin errors++; $display("FAIL load_r1: got %h expected 0000ffff", RdData); end
    do_op(5'h14, 3'd1, 3'd0, 1'b1, 32'd1, 3'd2, 1'b1, 1'b0, 2'd0, lat, skp, wfs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++; if (skp !== 1'b0) begin errors++; $display("FAIL add_skipped: got %b expected 0", skp); end
    checks++; if (wfs !== 1'b1) begin errors++; $display("FAIL add_wf: got %b expected 1", wfs); end
    RdSel = 3'd2; #1;
    checks++; if (RdData !== 32'h00010000) begin errors++; $display("FAIL add_r2: got %h expected 00010000", RdData); end
    checks++; if (AluFlags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b expected 0000", AluFlags); end
    checks++; if ({AluA, AluB, AluFunSel} !== {32'h0000FFFF, 32'd1, 5'h14}) begin
      errors++; $display("FAIL add_held_ins: got %h %h %h expected 0000ffff 00000001 14", AluA, AluB, AluFunSel); end
  endtask

  task automatic test_carry_chain();
    int lat; logic skp, wfs;
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'hFFFFFFFF, 3'd3, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    do_op(5'h14, 3'd3, 3'd0, 1'b1, 32'd1, 3'd4, 1'b1, 1'b0, 2'd0, lat, skp, wfs);
    RdSel = 3'd4; #1;
    checks++; if (RdData !== 32'd0) begin errors++; $display("FAIL carry_r4: got %h expected 00000000", RdData); end
    checks++; if (AluFlags !== 4'b1100) begin errors++; $display("FAIL carry_flags: got %b expected 1100", AluFlags); end
    do_op(5'h15, 3'd0, 3'd0, 1'b1, 32'd0, 3'd5, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    RdSel = 3'd5; #1;
    checks++; if (RdData !== 32'd1) begin errors++; $display("FAIL adc_r5: got %h expected 00000001", RdData); end
    checks++; if (wfs !== 1'b0) begin errors++; $display("FAIL adc_wf: got %b expected 0", wfs); end
    checks++; if (AluFlags !== 4'b1100) begin errors++; $display("FAIL adc_flags_kept: got %b expected 1100", AluFlags); end
  endtask

  task automatic test_width16();
    int lat; logic skp, wfs;
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'hABCD1234, 3'd6, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    do_op(5'h02, 3'd6, 3'd0, 1'b0, 32'd0, 3'd6, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    RdSel = 3'd6; #1;
    checks++; if (RdData !== 32'hABCDEDCB) begin errors++; $display("FAIL not16_r6: got %h expected abcdedcb", RdData); end
  endtask

  task automatic test_conditional();
    int lat; logic skp, wfs;
    // Flags are {Z,C,N,O}=1100 here: Z-conditional runs, O-conditional skips.
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'd9, 3'd7, 1'b0, 1'b1, 2'd3, lat, skp, wfs);
    checks++; if (skp !== 1'b0) begin errors++; $display("FAIL condz_taken_skipped: got %b expected 0", skp); end
    RdSel = 3'd7; #1;
    checks++; if (RdData !== 32'd9) begin errors++; $display("FAIL condz_taken_r7: got %h expected 00000009", RdData); end
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'd3, 3'd7, 1'b0, 1'b1, 2'd0, lat, skp, wfs);
    checks++; if (skp !== 1'b1) begin errors++; $display("FAIL condo_skipped: got %b expected 1", skp); end
    // Clear Z with a nonzero flag-writing add.
    do_op(5'h14, 3'd1, 3'd0, 1'b1, 32'd1, 3'd2, 1'b1, 1'b0, 2'd0, lat, skp, wfs);
    checks++; if (AluFlags !== 4'b0000) begin errors++; $display("FAIL cond_clear_flags: got %b expected 0000", AluFlags); end
    do_op(5'h11, 3'd0, 3'd0, 1'b1, 32'd5, 3'd7, 1'b1, 1'b1, 2'd3, lat, skp, wfs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL condz_skip_latency: got %0d expected 2", lat); end
    checks++; if (skp !== 1'b1) begin errors++; $display("FAIL condz_skip_skipped: got %b expected 1", skp); end
    checks++; if (wfs !== 1'b0) begin errors++; $display("FAIL condz_skip_wf: got %b expected 0", wfs); end
    RdSel = 3'd7; #1;
    checks++; if (RdData !== 32'd9) begin errors++; $display("FAIL condz_skip_r7: got %h expected 00000009", RdData); end
  endtask

  task automatic test_hazard();
    int lat; logic skp, wfs;
    // R2 = R2 + R2 with R2 = 0x00010000: operands are the pre-write value.
    do_op(5'h14, 3'd2, 3'd2, 1'b0, 32'd0, 3'd2, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    checks++; if (AluA !== 32'h00010000) begin errors++; $display("FAIL hazard_opa: got %h expected 00010000", AluA); end
    RdSel = 3'd2; #1;
    checks++; if (RdData !== 32'h00020000) begin errors++; $display("FAIL hazard_r2: got %h expected 00020000", RdData); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] done_pat, rdy_pat;
    @(negedge Clock);
    ReqFunSel = 5'h14; ReqSrcA = 3'd2; ReqSrcB = 3'd0; ReqImmEn = 1'b1; ReqImm = 32'd1;
    ReqDst = 3'd2; ReqWF = 1'b0; ReqCondEn = 1'b0; ReqCond = 2'd0; ReqValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      done_pat[i] = Done;
      rdy_pat[i]  = ReqReady;
    end
    ReqValid = 1'b0;
    checks++; if (done_pat !== 8'hAA) begin errors++; $display("FAIL b2b_done_pattern: got %b expected 10101010", done_pat); end
    checks++; if (rdy_pat !== 8'hAA) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 10101010", rdy_pat); end
    @(negedge Clock);
    RdSel = 3'd2; #1;
    checks++; if (RdData !== 32'h00020004) begin errors++; $display("FAIL b2b_r2: got %h expected 00020004", RdData); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done: got %b expected 0", Done); end
  endtask

  task automatic test_reset_abort();
    int lat; logic skp, wfs;
    @(negedge Clock);
    ReqFunSel = 5'h11; ReqSrcA = 3'd0; ReqSrcB = 3'd0; ReqImmEn = 1'b1; ReqImm = 32'h0000DEAD;
    ReqDst = 3'd7; ReqWF = 1'b1; ReqCondEn = 1'b0; ReqCond = 2'd0; ReqValid = 1'b1;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    @(negedge Clock);
    checks++; if (AluWF !== 1'b1) begin errors++; $display("FAIL abort_wf_before: got %b expected 1", AluWF); end
    Reset = 1'b0;
    #1;
    checks++; if (AluWF !== 1'b0) begin errors++; $display("FAIL abort_wf_drop: got %b expected 0", AluWF); end
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    RdSel = 3'd7; #1;
    checks++; if (RdData !== 32'd0) begin errors++; $display("FAIL abort_r7: got %h expected 00000000", RdData); end
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ReqReady); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", Done); end
    // 16-bit load after recovery: upper half of R7 stays zero.
    do_op(5'h01, 3'd0, 3'd0, 1'b1, 32'hFFFF1234, 3'd7, 1'b0, 1'b0, 2'd0, lat, skp, wfs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL recover_latency: got %0d expected 2", lat); end
    RdSel = 3'd7; #1;
    checks++; if (RdData !== 32'h00001234) begin errors++; $display("FAIL recover_r7: got %h expected 00001234", RdData); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_carry_chain();
    test_width16();
    test_conditional();
    test_hazard();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
